ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Iterative multiply/divide unit for the execute stage.
//  - Computes MULT, MULTU, DIV and DIVU into the architectural HI/LO pair.
//  - Services MTHI/MTLO writes; HI/LO are driven out continuously for MFHI/MFLO.
//  - Sits beside the single-cycle ALU. The pipeline stalls on EX_md_busy.
// PARAMETERS
//  WIDTH  32  operand, HI and LO width; must be >= 4.
// PORTS
//  clk           in   1      sole clock, rising edge
//  rst           in   1      synchronous, active-high reset
//  EX_md_start   in   1      request; sampled only when idle
//  EX_md_op      in   3      100 MULT, 101 MULTU, 110 DIV, 111 DIVU, 010 MTHI, 011 MTLO
//  EX_md_a       in   WIDTH  multiplicand / dividend / MTHI-MTLO data
//  EX_md_b       in   WIDTH  multiplier / divisor
//  EX_md_flush   in   1      abort the operation in flight
//  EX_md_busy    out  1      iteration in progress
//  EX_md_done    out  1      one-cycle pulse; HI/LO hold the new result
//  EX_md_hi      out  WIDTH  HI register
//  EX_md_lo      out  WIDTH  LO register
//  EX_md_div0    out  1      sticky divide-by-zero flag (only with the macro)
// BEHAVIOUR
//  Reset: HI=0, LO=0, busy=0, done=0, div0=0, state IDLE. Reset wins over every other input.
//  Reset mid-operation discards the operation.
//  FSM states: IDLE, CALC, FIX.
//  - IDLE -> CALC on start with a MULT/DIV op (edge E0).
//    Operands are latched; signed ops store magnitudes and result signs.
//  - CALC runs edges E1..E_WIDTH, one shift-add or restoring-subtract step per edge,
//    with a WIDTH-cycle down-counter.
//  - CALC -> FIX when the counter reaches 0.
//  - FIX applies sign correction and writes HI/LO at edge E_WIDTH+1, then returns to IDLE.
//  Outputs:
//  - busy=1 after E0 through E_WIDTH+1; it falls on the same edge that done rises.
//  - done=1 for exactly the one cycle after E_WIDTH+1.
//  - Back-to-back: a new start may be sampled in the done cycle.
//  MTHI/MTLO: with start while idle, HI (or LO) := EX_md_a at the next edge. No busy, no done.
//  Start while busy: ignored, including MTHI/MTLO. Op codes 000/001: start is ignored.
//  Flush: in CALC or FIX, the next edge returns to IDLE with busy=0 and no done.
//  HI/LO keep their prior values. Flush together with start in IDLE: start is ignored.
//  Arithmetic:
//  - MULT/MULTU: {HI,LO} = full 2*WIDTH product.
//  - DIV/DIVU: LO=quotient, HI=remainder. Quotient truncates toward zero.
//    The remainder takes the sign of the dividend.
//  - Signed most-negative / -1: LO=most-negative, HI=0 (wrap, no trap).
//  - Divisor 0 (signed or unsigned): LO=all-ones, HI=dividend, same latency.
// CONFIGURATION
//  Macro: MULDIV_DIV0_FLAG_EN.
//  - Defined: port EX_md_div0 exists. It sets at the FIX edge of any DIV/DIVU with b==0.
//    It clears only on reset or on MTLO.
//  - Undefined: the port and its register are absent. Results are identical.
// STRUCTURE
//  Shared package muldiv_pkg holds:
//  - op-code constants (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
//  - FSM state encodings (MD_IDLE, MD_CALC, MD_FIX).
//  Sub-module muldiv_step: combinational single iteration.
//  - Inputs: partial remainder/product, operand, mode.
//  - Outputs: next partial and the quotient bit.
// TESTING (WIDTH=32)
//  1. MULTU FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE, LO=00000001. done exactly 33 edges after the start edge.
//  2. MULT -10*12 -> HI=FFFFFFFF, LO=FFFFFF88. DIV -10/3 -> LO=FFFFFFFD, HI=FFFFFFFF.
//  3. DIVU 10/12 -> LO=0, HI=0000000A. DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
//  4. DIVU 7/0 -> LO=FFFFFFFF, HI=7. div0=1 with the macro; MTLO 0 -> div0=0.
//  5. MTHI 1234 while idle -> HI=1234 next edge. MULT start, 2nd start at E3 -> ignored.
//     Flush at E5 -> busy=0 next cycle, no done, HI/LO unchanged.
//  6. rst at E10 of DIVU -> HI=LO=0, busy=done=0. A new MULTU 3*4 completes -> LO=C.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the execute-stage multiply/divide unit: op codes and FSM states.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'b100;
    localparam logic [2:0] MD_MULTU = 3'b101;
    localparam logic [2:0] MD_DIV   = 3'b110;
    localparam logic [2:0] MD_DIVU  = 3'b111;
    localparam logic [2:0] MD_MTHI  = 3'b010;
    localparam logic [2:0] MD_MTLO  = 3'b011;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Bit 0 clear marks the signed flavour of both MULT and DIV.
    function automatic logic md_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
// bit_o is the bit shifted into the low word (product LSB chain or quotient bit).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] part_i,
    input  logic             mbit_i,
    input  logic             dbit_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             div_i,
    output logic [WIDTH-1:0] part_o,
    output logic             bit_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum  = {1'b0, part_i} + (mbit_i ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        // Shifted remainder is {part_i[WIDTH-1], shl}; a set top bit always exceeds the divisor.
        shl  = {part_i[WIDTH-2:0], dbit_i};
        ge   = part_i[WIDTH-1] | (shl >= opnd_i);
        diff = shl - opnd_i;
        if (div_i) begin
            part_o = ge ? diff : shl;
            bit_o  = ge;
        end else begin
            part_o = sum[WIDTH:1];
            bit_o  = sum[0];
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Optional sticky divide-by-zero flag output under macro MULDIV_DIV0_FLAG_EN.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EX_md_start,
    input  logic [2:0]       EX_md_op,
    input  logic [WIDTH-1:0] EX_md_a,
    input  logic [WIDTH-1:0] EX_md_b,
    input  logic             EX_md_flush,
    output logic             EX_md_busy,
    output logic             EX_md_done,
    output logic [WIDTH-1:0] EX_md_hi,
`ifdef MULDIV_DIV0_FLAG_EN
    output logic [WIDTH-1:0] EX_md_lo,
    output logic             EX_md_div0
`else
    output logic [WIDTH-1:0] EX_md_lo
`endif
);

    localparam int CW = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
`ifdef MULDIV_DIV0_FLAG_EN
    logic             div0_q, div0_d;
`endif

    logic             sgn, sa, sb, bz;
    logic [WIDTH-1:0] amag, bmag;
    logic [WIDTH-1:0] step_part;
    logic             step_bit;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .part_i (part_q),
        .mbit_i (low_q[0]),
        .dbit_i (low_q[WIDTH-1]),
        .opnd_i (opnd_q),
        .div_i  (div_q),
        .part_o (step_part),
        .bit_o  (step_bit)
    );

    always_comb begin
        sgn  = md_is_signed(EX_md_op);
        sa   = sgn & EX_md_a[WIDTH-1];
        sb   = sgn & EX_md_b[WIDTH-1];
        bz   = (EX_md_b == '0);
        amag = sa ? -EX_md_a : EX_md_a;
        bmag = sb ? -EX_md_b : EX_md_b;
        // Magnitude results are fixed up once in FIX; -MIN wraps to MIN, giving the no-trap result.
        prod     = {part_q, low_q};
        prod_fix = negq_q ? -prod : prod;
        quot_fix = negq_q ? -low_q : low_q;
        rem_fix  = negr_q ? -part_q : part_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        low_d   = low_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        bzero_d = bzero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
        div0_d  = div0_q;
`endif
        case (state_q)
            MD_IDLE: begin
                if (EX_md_start && !EX_md_flush) begin
                    if (EX_md_op[2]) begin
                        state_d = MD_CALC;
                        cnt_d   = CW'(WIDTH - 1);
                        part_d  = '0;
                        div_d   = EX_md_op[1];
                        low_d   = EX_md_op[1] ? amag : bmag;
                        opnd_d  = EX_md_op[1] ? bmag : amag;
                        bzero_d = bz;
                        // A zero divisor keeps the all-ones quotient unsigned regardless of dividend sign.
                        negq_d  = (sa ^ sb) & ~(EX_md_op[1] & bz);
                        negr_d  = sa;
                    end else if (EX_md_op == MD_MTHI) begin
                        hi_d = EX_md_a;
                    end else if (EX_md_op == MD_MTLO) begin
                        lo_d = EX_md_a;
`ifdef MULDIV_DIV0_FLAG_EN
                        div0_d = 1'b0;
`endif
                    end
                end
            end
            MD_CALC: begin
                if (EX_md_flush) begin
                    state_d = MD_IDLE;
                end else begin
                    part_d = step_part;
                    low_d  = div_q ? {low_q[WIDTH-2:0], step_bit} : {step_bit, low_q[WIDTH-1:1]};
                    if (cnt_q == '0) begin
                        state_d = MD_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (!EX_md_flush) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
`ifdef MULDIV_DIV0_FLAG_EN
                        if (bzero_q) begin
                            div0_d = 1'b1;
                        end
`endif
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
            div0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_DIV0_FLAG_EN
            div0_q  <= div0_d;
`endif
        end
    end

    // Iteration working registers carry no reset; they are reloaded on every accepted op.
    always_ff @(posedge clk) begin
        part_q  <= part_d;
        low_q   <= low_d;
        opnd_q  <= opnd_d;
        div_q   <= div_d;
        negq_q  <= negq_d;
        negr_q  <= negr_d;
        bzero_q <= bzero_d;
    end

    assign EX_md_busy = (state_q != MD_IDLE);
    assign EX_md_done = done_q;
    assign EX_md_hi   = hi_q;
    assign EX_md_lo   = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
    assign EX_md_div0 = div0_q;
`endif

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv (WIDTH=32) with hand-computed HI/LO results.
module tb_ex_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;
`ifdef MULDIV_DIV0_FLAG_EN
    logic         div0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int e;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .EX_md_start (start),
        .EX_md_op    (op),
        .EX_md_a     (a),
        .EX_md_b     (b),
        .EX_md_flush (flush),
        .EX_md_busy  (busy),
        .EX_md_done  (done),
        .EX_md_hi    (hi),
`ifdef MULDIV_DIV0_FLAG_EN
        .EX_md_lo    (lo),
        .EX_md_div0  (div0)
`else
        .EX_md_lo    (lo)
`endif
    );

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got=%h want=%h", hi, 32'h0); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got=%h want=%h", lo, 32'h0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
`ifdef MULDIV_DIV0_FLAG_EN
        n_cmp++; if (div0 !== 1'b0) begin n_bad++; $display("FAIL reset_div0 got=%b want=0", div0); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_multu_back_to_back();
        issue(3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL multu_busy got=%b want=1", busy); end
        wait_done(e);
        n_cmp++; if (e != 33) begin n_bad++; $display("FAIL multu_latency got=%0d want=33", e); end
        n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_hi got=%h want=%h", hi, 32'hFFFFFFFE); end
        n_cmp++; if (lo !== 32'h00000001) begin n_bad++; $display("FAIL multu_lo got=%h want=%h", lo, 32'h00000001); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL multu_busy_at_done got=%b want=0", busy); end
        // Start sampled during the done cycle.
        issue(3'b111, 32'd100, 32'd7);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_pulse got=%b want=0", done); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
        wait_done(e);
        n_cmp++; if (e != 33) begin n_bad++; $display("FAIL b2b_latency got=%0d want=33", e); end
        n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL b2b_lo got=%h want=%h", lo, 32'd14); end
        n_cmp++; if (hi !== 32'd2) begin n_bad++; $display("FAIL b2b_hi got=%h want=%h", hi, 32'd2); end
    endtask

    task automatic test_signed();
        issue(3'b100, 32'hFFFFFFF6, 32'd12);
        wait_done(e);
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi got=%h want=%h", hi, 32'hFFFFFFFF); end
        n_cmp++; if (lo !== 32'hFFFFFF88) begin n_bad++; $display("FAIL mult_lo got=%h want=%h", lo, 32'hFFFFFF88); end
        issue(3'b110, 32'hFFFFFFF6, 32'd3);
        wait_done(e);
        n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_lo got=%h want=%h", lo, 32'hFFFFFFFD); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_hi got=%h want=%h", hi, 32'hFFFFFFFF); end
    endtask

    task automatic test_div_edges();
        issue(3'b111, 32'd10, 32'd12);
        wait_done(e);
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL divu_small_lo got=%h want=%h", lo, 32'h0); end
        n_cmp++; if (hi !== 32'hA) begin n_bad++; $display("FAIL divu_small_hi got=%h want=%h", hi, 32'hA); end
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF);
        wait_done(e);
        n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL div_ovf_lo got=%h want=%h", lo, 32'h80000000); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL div_ovf_hi got=%h want=%h", hi, 32'h0); end
    endtask

    task automatic test_div0();
        issue(3'b111, 32'd7, 32'd0);
        wait_done(e);
        n_cmp++; if (e != 33) begin n_bad++; $display("FAIL divu0_latency got=%0d want=33", e); end
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL divu0_lo got=%h want=%h", lo, 32'hFFFFFFFF); end
        n_cmp++; if (hi !== 32'd7) begin n_bad++; $display("FAIL divu0_hi got=%h want=%h", hi, 32'd7); end
`ifdef MULDIV_DIV0_FLAG_EN
        n_cmp++; if (div0 !== 1'b1) begin n_bad++; $display("FAIL divu0_flag got=%b want=1", div0); end
`endif
        issue(3'b110, 32'hFFFFFFF6, 32'd0);
        wait_done(e);
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div0_signed_lo got=%h want=%h", lo, 32'hFFFFFFFF); end
        n_cmp++; if (hi !== 32'hFFFFFFF6) begin n_bad++; $display("FAIL div0_signed_hi got=%h want=%h", hi, 32'hFFFFFFF6); end
        issue(3'b011, 32'd0, 32'd0);
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL mtlo_lo got=%h want=%h", lo, 32'h0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy got=%b want=0", busy); end
`ifdef MULDIV_DIV0_FLAG_EN
        n_cmp++; if (div0 !== 1'b0) begin n_bad++; $display("FAIL mtlo_div0_clear got=%b want=0", div0); end
`endif
    endtask

    task automatic test_mthi_flush();
        issue(3'b010, 32'h1234, 32'd0);
        n_cmp++; if (hi !== 32'h1234) begin n_bad++; $display("FAIL mthi_hi got=%h want=%h", hi, 32'h1234); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mthi_done got=%b want=0", done); end
        issue(3'b000, 32'h5555, 32'h5555);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL op000_busy got=%b want=0", busy); end
        n_cmp++; if (hi !== 32'h1234) begin n_bad++; $display("FAIL op000_hi got=%h want=%h", hi, 32'h1234); end
        flush = 1'b1;
        issue(3'b010, 32'h9999, 32'd0);
        flush = 1'b0;
        n_cmp++; if (hi !== 32'h1234) begin n_bad++; $display("FAIL flush_start_hi got=%h want=%h", hi, 32'h1234); end
        issue(3'b100, 32'd7, 32'd9);
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b1; op = 3'b011; a = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL start_busy_ign_busy got=%b want=1", busy); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL start_busy_ign_lo got=%h want=%h", lo, 32'h0); end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_done got=%b want=0", done); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_done_later got=%b want=0", done); end
        n_cmp++; if (hi !== 32'h1234) begin n_bad++; $display("FAIL flush_hi got=%h want=%h", hi, 32'h1234); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL flush_lo got=%h want=%h", lo, 32'h0); end
    endtask

    task automatic test_reset_mid_op();
        issue(3'b111, 32'd64, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL midrst_hi got=%h want=%h", hi, 32'h0); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL midrst_lo got=%h want=%h", lo, 32'h0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b want=0", done); end
        issue(3'b101, 32'd3, 32'd4);
        wait_done(e);
        n_cmp++; if (e != 33) begin n_bad++; $display("FAIL post_rst_latency got=%0d want=33", e); end
        n_cmp++; if (lo !== 32'hC) begin n_bad++; $display("FAIL post_rst_lo got=%h want=%h", lo, 32'hC); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL post_rst_hi got=%h want=%h", hi, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_multu_back_to_back();
        test_signed();
        test_div_edges();
        test_div0();
        test_mthi_flush();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
